// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared state/bank types and saturation classifier for the FIR MAC engine
package fir_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  typedef enum logic [1:0] {BANK_LP, BANK_B1, BANK_B2, BANK_HP} bank_t;

  typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_t;

  // Classifies a sign-extended value against the signed range of an i_w-bit result.
  function automatic sat_t sat(input logic signed [63:0] i_val, input int unsigned i_w);
    logic signed [63:0] w_hi;
    logic signed [63:0] w_lo;
    w_hi = (64'sd1 <<< (i_w - 1)) - 64'sd1;
    w_lo = -(64'sd1 <<< (i_w - 1));
    if (i_val > w_hi) begin
      sat = SAT_POS;
    end else if (i_val < w_lo) begin
      sat = SAT_NEG;
    end else begin
      sat = SAT_NONE;
    end
  endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// rtl/fir_mac_engine_if.sv - sample queue, coefficient ROM and output bundle of the FIR MAC engine
interface fir_mac_engine_if #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NUM_TAPS  = 1021,
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ADDR_W = $clog2(NUM_BANKS * NUM_TAPS);

  logic                       sequencing;
  logic [BANK_W-1:0]          bank_sel;
  logic [NUM_CH*DATA_W-1:0]   smpl_in;
  logic [ADDR_W-1:0]          coef_addr;
  logic [COEF_W-1:0]          coef_in;
  logic [NUM_CH*DATA_W-1:0]   smpl_out;
  logic                       vld;
  logic                       busy;
  logic [NUM_CH-1:0]          ovf;
  logic                       ovf_clr;

  modport master (
    output sequencing, bank_sel, smpl_in, coef_in, ovf_clr,
    input  coef_addr, smpl_out, vld, busy, ovf
  );

  modport slave (
    input  sequencing, bank_sel, smpl_in, coef_in, ovf_clr,
    output coef_addr, smpl_out, vld, busy, ovf
  );

endinterface

// File: rtl/fir_mac_lane.sv
// rtl/fir_mac_lane.sv - one channel: signed MAC accumulator, Q-format shift and output saturation
module fir_mac_lane
  import fir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 42
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_smpl,
  input  logic signed [COEF_W-1:0] i_coef,
  output logic [DATA_W-1:0]        o_res,
  output logic                     o_sat
);

  logic signed [DATA_W+COEF_W-1:0] w_prod;
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [ACC_W-1:0]         w_shift;
  sat_t                            w_sat;

  assign w_prod  = i_smpl * i_coef;
  // Drop the Q1.(COEF_W-1) fraction; arithmetic shift floors toward minus infinity.
  assign w_shift = r_acc >>> (COEF_W - 1);
  assign w_sat   = sat(64'(w_shift), DATA_W);
  assign o_sat   = (w_sat != SAT_NONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  always_comb begin
    o_res = w_shift[DATA_W-1:0];
    case (w_sat)
      SAT_POS: o_res = {1'b0, {(DATA_W-1){1'b1}}};
      SAT_NEG: o_res = {1'b1, {(DATA_W-1){1'b0}}};
      default: o_res = w_shift[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - multi-channel FIR MAC engine: frame FSM, tap counter, ROM addressing, output regs
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int NUM_TAPS  = 1021,
  parameter int NUM_BANKS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fir_mac_engine_if.slave  bus
);

  localparam int ADDR_W = $clog2(NUM_BANKS * NUM_TAPS);
  localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(NUM_TAPS);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic                     r_seq_d;
  logic [TAP_W-1:0]         r_tap;
  logic [ADDR_W-1:0]        r_coef_addr;
  logic [ADDR_W-1:0]        w_base;
  logic [NUM_CH*DATA_W-1:0] r_smpl_out;
  logic [NUM_CH*DATA_W-1:0] w_res;
  logic                     r_vld;
  logic [NUM_CH-1:0]        r_ovf;
  logic [NUM_CH-1:0]        w_sat;
  logic                     w_start;
  logic                     w_abort;
  logic                     w_acc_en;
  logic                     w_done;
  logic                     w_addr_adv;

  assign w_base     = ADDR_W'((int'(bus.bank_sel) % NUM_BANKS) * NUM_TAPS);
  // The address runs one tap ahead of the data; stop at the bank's last word.
  assign w_addr_adv = (int'(r_tap) + 2) < NUM_TAPS;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_abort     = 1'b0;
    w_acc_en    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sequencing && !r_seq_d) begin
          w_start     = 1'b1;
          w_state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (!bus.sequencing) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_acc_en = 1'b1;
          if (r_tap == TAP_W'(NUM_TAPS - 1)) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seq_d     <= 1'b0;
      r_tap       <= '0;
      r_coef_addr <= '0;
      r_smpl_out  <= '0;
      r_vld       <= 1'b0;
      r_ovf       <= '0;
    end else begin
      r_seq_d <= bus.sequencing;
      r_vld   <= w_done;
      // A saturation in the same cycle as ovf_clr keeps its flag.
      r_ovf   <= (r_ovf & ~{NUM_CH{bus.ovf_clr}}) | (w_sat & {NUM_CH{w_done}});
      if (w_start) begin
        r_tap <= '0;
      end else if (w_acc_en) begin
        r_tap <= r_tap + TAP_W'(1);
      end
      if (w_done) begin
        r_smpl_out <= w_res;
      end
      // The address presented during T0 already fetched tap 0, which fixes the bank.
      case (r_state)
        IDLE:    r_coef_addr <= w_start ? r_coef_addr + ADDR_W'(1) : w_base;
        ACCUM:   if (w_acc_en && w_addr_adv) r_coef_addr <= r_coef_addr + ADDR_W'(1);
        default: r_coef_addr <= r_coef_addr;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    fir_mac_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_clr   (w_start | w_abort),
      .i_en    (w_acc_en),
      .i_smpl  (bus.smpl_in[c*DATA_W +: DATA_W]),
      .i_coef  (bus.coef_in),
      .o_res   (w_res[c*DATA_W +: DATA_W]),
      .o_sat   (w_sat[c])
    );
  end

  assign bus.coef_addr = r_coef_addr;
  assign bus.smpl_out  = r_smpl_out;
  assign bus.vld       = r_vld;
  assign bus.busy      = (r_state != IDLE);
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine (8 taps, 4 banks, 2 channels)
module tb_fir_mac_engine;
  import fir_pkg::*;

  localparam int NT = 8;

  typedef struct packed {
    logic [1:0]        bank;
    logic [7:0][15:0]  s0;
    logic [7:0][15:0]  s1;
    logic [7:0][15:0]  coef;
    logic [15:0]       exp0;
    logic [15:0]       exp1;
    logic [1:0]        exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [15:0] e0;
    logic [15:0] e1;
    logic [31:0] at;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] rom [0:31];
  vec_t        vecs [7];
  exp_t        sbq [$];
  int          checks;
  int          errors;
  int          cyc;

  fir_mac_engine_if #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .NUM_TAPS(NT), .NUM_BANKS(4)) bus_if ();

  fir_mac_engine #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .NUM_TAPS(NT), .NUM_BANKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus_if.coef_in <= rom[bus_if.coef_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] b, input logic [15:0] s0v, input logic [15:0] s1v,
                              input logic [15:0] cv, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [1:0] eo);
    vec_t v;
    v.bank = b; v.s0 = {8{s0v}}; v.s1 = {8{s1v}}; v.coef = {8{cv}};
    v.exp0 = e0; v.exp1 = e1; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic pulse_clr;
    bus_if.ovf_clr = 1'b1;
    tick;
    bus_if.ovf_clr = 1'b0;
    check("ovf_cleared", bus_if.ovf, 2'b00);
  endtask

  task automatic run_frame(input vec_t v, input int abort_at, input int rst_at,
                           input bit hold_high, input bit clr_in_done, input bit bank_flip);
    int          t0, lo, hi, bad, base;
    logic [31:0] prev_out;
    bit          seen;
    exp_t        e;
    base = int'(v.bank) * NT;
    for (int k = 0; k < NT; k++) rom[base + k] = v.coef[k];
    bus_if.bank_sel = v.bank;
    tick;
    check("base_addr", bus_if.coef_addr, base);
    prev_out = bus_if.smpl_out;
    bus_if.sequencing = 1'b1;
    t0 = cyc; lo = base; hi = base;
    if (abort_at == 0 && rst_at == 0) begin
      e.e0 = v.exp0; e.e1 = v.exp1; e.at = 32'(t0 + NT + 2);
      sbq.push_back(e);
    end
    for (int k = 1; k <= NT; k++) begin
      tick;
      if (k == abort_at || k == rst_at) break;
      bus_if.smpl_in = {v.s1[k-1], v.s0[k-1]};
      if (bank_flip && k == 2) bus_if.bank_sel = BANK_LP;
      if (int'(bus_if.coef_addr) < lo) lo = int'(bus_if.coef_addr);
      if (int'(bus_if.coef_addr) > hi) hi = int'(bus_if.coef_addr);
    end
    if (abort_at != 0) begin
      bus_if.sequencing = 1'b0;
      bus_if.smpl_in = '0;
      tick;
      check("abort_idle", bus_if.busy, 1'b0);
      bad = 0;
      repeat (12) begin
        if (bus_if.vld || bus_if.smpl_out !== prev_out) bad++;
        tick;
      end
      check("abort_quiet", bad, 0);
      return;
    end
    if (rst_at != 0) begin
      rst_n = 1'b0;
      tick;
      check("reset_mid", {bus_if.smpl_out, bus_if.ovf, bus_if.vld, bus_if.busy, bus_if.coef_addr}, 64'd0);
      bus_if.sequencing = 1'b0;
      bus_if.smpl_in = '0;
      tick;
      rst_n = 1'b1;
      tick;
      return;
    end
    tick;
    check("busy_done", bus_if.busy, 1'b1);
    check("addr_lo", lo, base);
    check("addr_hi", hi, base + NT - 1);
    bus_if.smpl_in = '0;
    if (clr_in_done) bus_if.ovf_clr = 1'b1;
    if (!hold_high) bus_if.sequencing = 1'b0;
    tick;
    bus_if.ovf_clr = 1'b0;
    seen = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (bus_if.vld) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    check("vld_seen", seen, 1'b1);
    if (seen) begin
      check("sb_size", sbq.size(), 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("vld_cycle", cyc, e.at);
        check("out_ch0", bus_if.smpl_out[15:0], e.e0);
        check("out_ch1", bus_if.smpl_out[31:16], e.e1);
      end
      tick;
      check("vld_strobe", bus_if.vld, 1'b0);
    end
    if (hold_high) begin
      bad = 0;
      repeat (4) begin
        if (bus_if.busy) bad++;
        tick;
      end
      check("no_retrigger", bad, 0);
      bus_if.sequencing = 1'b0;
      tick;
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0;
    bus_if.sequencing = 1'b0;
    bus_if.bank_sel   = '0;
    bus_if.smpl_in    = '0;
    bus_if.ovf_clr    = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0100 + 16'(i * 3);

    vecs[0] = mk(BANK_LP, 16'h0000, 16'h0000, 16'h2345, 16'h3FFF, 16'h0000, 2'b00);
    vecs[0].s0[0] = 16'h7FFF; vecs[0].coef[0] = 16'h4000;
    vecs[1] = mk(BANK_B1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 2'b11);
    vecs[2] = mk(BANK_B2, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'h8000, 2'b10);
    vecs[3] = mk(BANK_HP, 16'h0064, 16'hFF9C, 16'h4000, 16'h0190, 16'hFE70, 2'b00);
    vecs[4] = mk(BANK_B1, 16'h03E8, 16'hFFFF, 16'h2000, 16'h07D0, 16'hFFFE, 2'b00);
    vecs[5] = mk(BANK_LP, 16'h7FFF, 16'h8000, 16'h0000, 16'h7FFF, 16'h8000, 2'b00);
    vecs[5].coef[0] = 16'h4000; vecs[5].coef[1] = 16'h4000;
    vecs[6] = mk(BANK_B2, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 2'b01);
    vecs[6].s0[0] = 16'h7FFF; vecs[6].s0[1] = 16'h7FFF; vecs[6].s0[2] = 16'h0002;
    vecs[6].coef[0] = 16'h4000; vecs[6].coef[1] = 16'h4000; vecs[6].coef[2] = 16'h4000;

    repeat (3) tick;
    check("reset_state", {bus_if.smpl_out, bus_if.ovf, bus_if.vld, bus_if.busy, bus_if.coef_addr}, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick;

    for (int i = 0; i < 7; i++) begin
      pulse_clr();
      run_frame(vecs[i], 0, 0, 1'b0, 1'b0, 1'b0);
      check("ovf_after", bus_if.ovf, vecs[i].exp_ovf);
      if (vecs[i].exp_ovf != 2'b00) begin
        repeat (4) tick;
        check("ovf_sticky", bus_if.ovf, vecs[i].exp_ovf);
      end
    end

    // Saturation and ovf_clr in the same cycle: ch1 flag cleared, ch0 flag set.
    run_frame(vecs[2], 0, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_both", bus_if.ovf, 2'b11);
    run_frame(vecs[6], 0, 0, 1'b0, 1'b1, 1'b0);
    check("ovf_set_wins", bus_if.ovf, 2'b01);

    run_frame(vecs[3], 0, 0, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < NT; k++) rom[k] = 16'h7FFF;
    run_frame(vecs[3], 0, 0, 1'b0, 1'b0, 1'b1);

    run_frame(vecs[4], 4, 0, 1'b0, 1'b0, 1'b0);
    run_frame(vecs[5], 0, 0, 1'b0, 1'b0, 1'b0);

    run_frame(vecs[2], 0, 0, 1'b0, 1'b0, 1'b0);
    run_frame(vecs[1], 0, 5, 1'b0, 1'b0, 1'b0);
    run_frame(vecs[0], 0, 0, 1'b0, 1'b0, 1'b0);
    check("ovf_post_reset", bus_if.ovf, 2'b00);
    check("sb_drained", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
